// File: rtl/dc_line_wb_pkg.sv
// Shared dcache writeback definitions: geometry, FSM state encodings, word offset codes.
package dc_line_wb_pkg;

    localparam int DC_INDEX_W = 8;
    localparam int DC_TAG_W   = 20;
    localparam int DC_LINE_W  = 128;
    localparam int DC_WORD_W  = 32;

    typedef enum logic [2:0] {
        WB_IDLE,
        WB_READ,
        WB_CAPT,
        WB_SEND,
        WB_DONE
    } wb_state_e;

    localparam logic [1:0] WORD0 = 2'd0;
    localparam logic [1:0] WORD1 = 2'd1;
    localparam logic [1:0] WORD2 = 2'd2;
    localparam logic [1:0] WORD3 = 2'd3;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/dc_line_wb_if.sv
// L2 write port: one word per valid/ready handshake, last marks the final word of a line.
interface dc_line_wb_if import dc_line_wb_pkg::*; #(
    parameter int WORD_W = DC_WORD_W
);
    logic              l2_wb_valid;
    logic              l2_wb_ready;
    logic [31:0]       l2_wb_addr;
    logic [WORD_W-1:0] l2_wb_data;
    logic              l2_wb_last;

    modport master (
        output l2_wb_valid, l2_wb_addr, l2_wb_data, l2_wb_last,
        input  l2_wb_ready
    );

    modport slave (
        input  l2_wb_valid, l2_wb_addr, l2_wb_data, l2_wb_last,
        output l2_wb_ready
    );
endinterface

// File: rtl/dc_line_wb.sv
// Dirty-line writeback engine: reads one victim line from the data RAM and streams it to L2.
//   state   | meaning
//   WB_IDLE | waiting for wb_req, latches way/index/tag
//   WB_READ | read enable to the victim way for one cycle
//   WB_CAPT | RAM data valid, load the line buffer
//   WB_SEND | present word_cnt to L2, advance on ready
//   WB_DONE | one-cycle done pulse, requests not accepted
module dc_line_wb import dc_line_wb_pkg::*; #(
    parameter int INDEX_W = DC_INDEX_W,
    parameter int TAG_W   = DC_TAG_W,
    parameter int LINE_W  = DC_LINE_W,
    parameter int WORD_W  = DC_WORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_req,
    input  logic               wb_way,
    input  logic [INDEX_W-1:0] wb_index,
    input  logic [TAG_W-1:0]   wb_tag,
    output logic               wb_busy,
    output logic               wb_done,
    output logic [INDEX_W-1:0] ram_index,
    output logic               block0_re,
    output logic               block1_re,
    input  logic [LINE_W-1:0]  data0_rd,
    input  logic [LINE_W-1:0]  data1_rd,
    dc_line_wb_if.master       l2_wb
);

    wb_state_e          state_q, state_d;
    logic               way_q, way_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [LINE_W-1:0]  line_q, line_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= WB_IDLE;
            way_q   <= 1'b0;
            index_q <= '0;
            tag_q   <= '0;
            cnt_q   <= WORD0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            way_q   <= way_d;
            index_q <= index_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        way_d   = way_q;
        index_d = index_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        line_d  = line_q;

        wb_busy           = DISABLE;
        wb_done           = DISABLE;
        ram_index         = '0;
        block0_re         = DISABLE;
        block1_re         = DISABLE;
        l2_wb.l2_wb_valid = DISABLE;
        l2_wb.l2_wb_addr  = '0;
        l2_wb.l2_wb_data  = '0;
        l2_wb.l2_wb_last  = DISABLE;

        unique case (state_q)
            WB_IDLE: begin
                if (wb_req) begin
                    way_d   = wb_way;
                    index_d = wb_index;
                    tag_d   = wb_tag;
                    state_d = WB_READ;
                end
            end
            WB_READ: begin
                wb_busy   = ENABLE;
                ram_index = index_q;
                block0_re = !way_q;
                block1_re = way_q;
                state_d   = WB_CAPT;
            end
            WB_CAPT: begin
                wb_busy   = ENABLE;
                ram_index = index_q;
                line_d    = way_q ? data1_rd : data0_rd;
                state_d   = WB_SEND;
            end
            WB_SEND: begin
                wb_busy           = ENABLE;
                ram_index         = index_q;
                l2_wb.l2_wb_valid = ENABLE;
                l2_wb.l2_wb_addr  = {tag_q, index_q, cnt_q, 2'b00};
                l2_wb.l2_wb_last  = (cnt_q == WORD3);
                unique case (cnt_q)
                    WORD0: l2_wb.l2_wb_data = line_q[0*WORD_W +: WORD_W];
                    WORD1: l2_wb.l2_wb_data = line_q[1*WORD_W +: WORD_W];
                    WORD2: l2_wb.l2_wb_data = line_q[2*WORD_W +: WORD_W];
                    WORD3: l2_wb.l2_wb_data = line_q[3*WORD_W +: WORD_W];
                endcase
                // Nothing moves without ready, so valid/addr/data hold across stalls.
                if (l2_wb.l2_wb_ready) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == WORD3) begin
                        state_d = WB_DONE;
                    end
                end
            end
            WB_DONE: begin
                wb_done   = ENABLE;
                ram_index = index_q;
                cnt_d     = WORD0;
                state_d   = WB_IDLE;
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

endmodule
